// File: rtl/sram_bus_arbiter_pkg.sv
// Shared IDs, SRAM size codes, grant-lock states and request payload for sram_bus_arbiter.
package sram_bus_arbiter_pkg;

    localparam logic REQ_ID_INST = 1'b0;
    localparam logic REQ_ID_DATA = 1'b1;

    localparam logic [1:0] SRAM_SIZE_B = 2'd0;
    localparam logic [1:0] SRAM_SIZE_H = 2'd1;
    localparam logic [1:0] SRAM_SIZE_W = 2'd2;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LOCK_INST = 2'd1,
        ARB_LOCK_DATA = 2'd2
    } arb_state_e;

    // Address-independent request fields carried alongside the address.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } req_fields_t;

endpackage

// File: rtl/req_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for accepted-but-unanswered bus transactions.
module req_id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    // Pop sees only registered occupancy, so a same-cycle push into an empty FIFO is not bypassed.
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and load/store (data) with grant locking.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-inst priority.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [STRB_W-1:0] bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic        locked;
    logic        lock_owner;
    logic        winner;
    logic        sel;
    logic        sel_req;
    logic        acc;
    logic        pop;
    logic        fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    req_fields_t inst_fields;
    req_fields_t data_fields;
    req_fields_t sel_fields;

    assign locked     = (state_q != ARB_IDLE);
    assign lock_owner = (state_q == ARB_LOCK_DATA) ? REQ_ID_DATA : REQ_ID_INST;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q names the requester preferred on the next contested grant.
    logic rr_q;

    always_ff @(posedge clk) begin
        if (reset)    rr_q <= REQ_ID_DATA;
        else if (acc) rr_q <= ~sel;
    end

    assign winner = (inst_req && data_req) ? rr_q
                  : (data_req ? REQ_ID_DATA : REQ_ID_INST);
`else
    assign winner = data_req ? REQ_ID_DATA : REQ_ID_INST;
`endif

    // A locked grant is never switched until its address phase is accepted.
    assign sel     = locked ? lock_owner : winner;
    assign sel_req = (sel == REQ_ID_DATA) ? data_req : inst_req;
    assign bus_req = sel_req && !fifo_full;
    assign acc     = bus_req && bus_addr_ok;
    assign pop     = bus_data_ok && !fifo_empty;

    assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb, wdata: data_wdata};
    assign sel_fields  = (sel == REQ_ID_DATA) ? data_fields : inst_fields;

    assign bus_wr    = sel_fields.wr;
    assign bus_size  = sel_fields.size;
    assign bus_wstrb = sel_fields.wstrb;
    assign bus_wdata = sel_fields.wdata;
    assign bus_addr  = (sel == REQ_ID_DATA) ? data_addr : inst_addr;

    assign inst_addr_ok = acc && (sel == REQ_ID_INST);
    assign data_addr_ok = acc && (sel == REQ_ID_DATA);

    // Responses return in issue order; the FIFO head names the owner.
    assign inst_data_ok = pop && (fifo_head == REQ_ID_INST);
    assign data_data_ok = pop && (fifo_head == REQ_ID_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    // Lock on an offered-but-unaccepted request; hold while stalled (e.g. FIFO full).
    always_comb begin
        state_d = state_q;
        if (acc) begin
            state_d = ARB_IDLE;
        end else if (bus_req) begin
            state_d = (sel == REQ_ID_DATA) ? ARB_LOCK_DATA : ARB_LOCK_INST;
        end
    end

    req_id_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_req_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (acc),
        .push_id (sel),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
